accumulator_sequencer: RTL and testbench

//  Job controller for the Accumulator datapath. It accepts one job start with a sample count.
//  It feeds that many samples from a valid/ready input stream into the accumulator as

---
 rtl/accumulator_sequencer.sv | 119 +++++++++++
 tb/tb_accumulator_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_sequencer.sv
// Job controller for one Accumulator: clears it, feeds N stream samples as
// enable strobes, then reads and captures the sum.
module accumulator_sequencer #(
    parameter int Word_Length = 8,
    parameter int CNT_W       = 8,
    parameter int READ_WAIT   = 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [Word_Length-1:0] in_data,
    output logic                   in_ready,
    output logic                   acc_clear,
    output logic                   acc_enable,
    output logic [Word_Length-1:0] acc_data,
    output logic                   acc_read,
    input  logic [Word_Length-1:0] acc_result,
    output logic                   busy,
    output logic                   done,
    output logic                   result_valid,
    output logic [Word_Length-1:0] result
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        READ,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [3:0]       wait_cnt, wait_cnt_n;
    logic             xfer;
    logic             last_read;
    logic             kill;
    logic             zero_job;

    assign in_ready  = (state == FEED);
    assign xfer      = in_ready & in_valid;
    assign last_read = (wait_cnt == 4'(READ_WAIT));
    assign kill      = abort & (state != IDLE);
    assign zero_job  = (num_samples == '0);

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        wait_cnt_n  = wait_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (zero_job) begin
                        state_n = DONE;
                    end else begin
                        state_n     = CLEAR;
                        remaining_n = num_samples;
                    end
                end
            end
            CLEAR: state_n = FEED;
            FEED: begin
                if (xfer) begin
                    remaining_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_n    = READ;
                        wait_cnt_n = '0;
                    end
                end
            end
            READ: begin
                if (last_read) state_n = DONE;
                else wait_cnt_n = wait_cnt + 4'd1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort wins over any same-cycle transfer or completion
        if (kill) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            remaining    <= '0;
            wait_cnt     <= '0;
            acc_clear    <= 1'b0;
            acc_enable   <= 1'b0;
            acc_data     <= '0;
            acc_read     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            wait_cnt   <= wait_cnt_n;
            acc_clear  <= (state_n == CLEAR);
            acc_read   <= (state_n == READ);
            done       <= (state_n == DONE);
            busy       <= (state_n != IDLE);
            acc_enable <= xfer & ~kill;
            if (kill) acc_data <= '0;
            else if (xfer) acc_data <= in_data;
            if (state == READ && last_read && !kill)
                result <= acc_result;
            else if (state == IDLE && start && zero_job)
                result <= '0;
            if (kill) result_valid <= 1'b0;
            else if (state_n == DONE) result_valid <= 1'b1;
            else if (state == IDLE && start) result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench: timeline reference model of each job plus an
// accumulator model driven by the sequencer's strobes.
module tb_accumulator_sequencer;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int RW = 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [CW-1:0] num_samples;
    logic          abort;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          acc_clear;
    logic          acc_enable;
    logic [W-1:0]  acc_data;
    logic          acc_read;
    logic [W-1:0]  acc_result;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [W-1:0]  result;

    int           n_checks = 0;
    int           n_fails  = 0;
    bit           rv_exp   = 1'b0;
    logic [W-1:0] res_exp  = '0;
    logic [W-1:0] acc_sum;

    always #5 clk = ~clk;

    accumulator_sequencer #(
        .Word_Length(W),
        .CNT_W(CW),
        .READ_WAIT(RW)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .num_samples(num_samples),
        .abort(abort),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .acc_clear(acc_clear),
        .acc_enable(acc_enable),
        .acc_data(acc_data),
        .acc_read(acc_read),
        .acc_result(acc_result),
        .busy(busy),
        .done(done),
        .result_valid(result_valid),
        .result(result)
    );

    // Accumulator partner
    always @(posedge clk) begin
        if (!n_rst) acc_sum <= '0;
        else if (acc_clear) acc_sum <= '0;
        else if (acc_enable) acc_sum <= acc_sum + acc_data;
    end
    assign acc_result = acc_sum;

    function automatic logic [6:0] flags();
        return {in_ready, acc_clear, acc_enable, acc_read,
                busy, done, result_valid};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // vmode: percent valid, or <0 for the 1,0,0,1,0,1 pattern
    task automatic run_job(input int n, input int vmode,
                           input int abort_t, input bit spam,
                           input int fixdata);
        int           taken = 0;
        int           tl = -1;
        int           done_t;
        bit           aborted = 0;
        bit           kill = 0;
        bit           prev_xfer = 0;
        bit           fin = 0;
        bit           e_ready, e_busy, e_rv, v;
        logic [6:0]   ef;
        logic [5:0]   pat = 6'b101001;
        logic [W-1:0] sum = '0;
        logic [W-1:0] prev_data = '0;
        logic [W-1:0] d;
        done_t = (n == 0) ? 1 : -1;
        for (int t = 0; t < 400; t++) begin
            aborted = kill;
            if (n > 0 && tl >= 0) done_t = tl + 2 + RW;
            e_ready = !aborted && n > 0 && t >= 2 && taken < n;
            e_busy  = !aborted && t >= 1 && (done_t < 0 || t <= done_t);
            if (t == 0) e_rv = rv_exp;
            else e_rv = !aborted && done_t >= 0 && t >= done_t;
            ef = {e_ready,
                  !aborted && n > 0 && t == 1,
                  prev_xfer,
                  !aborted && tl >= 0 && t >= tl + 1 && t <= tl + 1 + RW,
                  e_busy,
                  !aborted && t == done_t,
                  e_rv};
            check($sformatf("flags n=%0d t=%0d", n, t), 32'(flags()), 32'(ef));
            if (t == 0 && rv_exp) check("result_hold", 32'(result), 32'(res_exp));
            if (prev_xfer) check("acc_data", 32'(acc_data), 32'(prev_data));
            if (aborted) begin
                check("abort_data", 32'(acc_data), 32'd0);
                fin = 1;
                break;
            end
            if (t == done_t) begin
                check($sformatf("result n=%0d", n), 32'(result), 32'(sum));
                fin = 1;
                break;
            end
            d = (fixdata < 0) ? W'($urandom) : W'(fixdata);
            if (vmode < 0) v = (t >= 2) ? pat[(t - 2) % 6] : 1'b0;
            else v = ($urandom_range(99) < vmode);
            start       = (t == 0) || (spam && e_busy && $urandom_range(3) == 0);
            num_samples = (t == 0) ? CW'(n) : CW'(7);
            abort       = (t == abort_t);
            in_valid    = v;
            in_data     = d;
            kill        = abort && e_busy;
            prev_xfer   = e_ready && v && !kill;
            if (prev_xfer) begin
                taken++;
                sum += d;
                prev_data = d;
                if (taken == n) tl = t;
            end
            @(negedge clk);
        end
        check("job_finished", 32'(fin), 32'd1);
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        if (aborted) begin
            rv_exp = 1'b0;
        end else if (fin) begin
            rv_exp  = 1'b1;
            res_exp = sum;
        end
        @(negedge clk);
    endtask

    initial begin
        int n, ab;
        n_rst       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        num_samples = '0;
        repeat (2) @(negedge clk);
        check("reset_flags", 32'(flags()), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        run_job(4, 100, -1, 0, 3);

        // reset in the middle of a feed
        start       = 1'b1;
        num_samples = CW'(10);
        in_valid    = 1'b1;
        in_data     = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check("midreset_flags", 32'(flags()), 32'd0);
        check("midreset_data", 32'(acc_data), 32'd0);
        check("midreset_result", 32'(result), 32'd0);
        n_rst    = 1'b1;
        in_valid = 1'b0;
        rv_exp   = 1'b0;
        @(negedge clk);

        run_job(100, 100, -1, 0, 3);
        run_job(3, -1, -1, 0, -1);
        run_job(6, 100, -1, 1, -1);
        run_job(5, 100, 3, 0, -1);
        run_job(0, 100, -1, 0, -1);
        run_job(5, 100, 0, 0, -1);
        run_job(1, 100, -1, 0, -1);

        for (int i = 0; i < 25; i++) begin
            n  = $urandom_range(0, 20);
            ab = ($urandom_range(3) == 0) ? $urandom_range(1, n + 4) : -1;
            run_job(n, $urandom_range(30, 100), ab,
                    1'($urandom_range(1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
